vending_ctrl_param: RTL and testbench

Parametrised vending controller succeeding the fixed six-drink, fixed-price machine. Supports N product slots with per-slot prices, tracks credit in nickel units, and keeps a live coin inventory for change. Pays change one coin at a time over a ready/valid handshake to the coin hopper. Sits between the coin acceptor/keypad front end and the dispenser/hopper actuators.

---
 rtl/vm_pkg.sv | 50 +++++
 rtl/vm_change_pick.sv | 36 +++
 rtl/vending_ctrl_param.sv | 195 +++++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared coin encodings, unit values and controller state for the vending controller.
// Pure definitions: no timing, no flow control.
package vm_pkg;

    localparam logic [2:0] COIN_NONE    = 3'b000;
    localparam logic [2:0] COIN_NICKEL  = 3'b001;
    localparam logic [2:0] COIN_DIME    = 3'b010;
    localparam logic [2:0] COIN_QUARTER = 3'b011;
    localparam logic [2:0] COIN_HALF    = 3'b100;
    localparam logic [2:0] COIN_DOLLAR  = 3'b101;

    localparam int U_NICKEL  = 1;
    localparam int U_DIME    = 2;
    localparam int U_QUARTER = 5;
    localparam int U_HALF    = 10;
    localparam int U_DOLLAR  = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    function automatic logic [4:0] coin_units(input logic [2:0] t);
        case (t)
            COIN_NICKEL:  return 5'(U_NICKEL);
            COIN_DIME:    return 5'(U_DIME);
            COIN_QUARTER: return 5'(U_QUARTER);
            COIN_HALF:    return 5'(U_HALF);
            COIN_DOLLAR:  return 5'(U_DOLLAR);
            default:      return 5'd0;
        endcase
    endfunction

    // Coins nickel..half map onto inventory slots 0..3; dollars go to the vault.
    function automatic logic coin_in_inv(input logic [2:0] t);
        return (t >= COIN_NICKEL) && (t <= COIN_HALF);
    endfunction

    function automatic logic [1:0] coin_slot(input logic [2:0] t);
        return t[1:0] - 2'd1;
    endfunction

    // A dollar on top of the ceiling must still fit in the credit register.
    function automatic bit max_credit_ok(input int credit_w, input int max_credit);
        return max_credit < ((1 << credit_w) - 20);
    endfunction

endpackage

// File: rtl/vm_change_pick.sv
// Greedy change picker: largest in-stock coin not exceeding the credit.
// Latency: combinational; no backpressure.
module vm_change_pick
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 8,
    parameter int INV_W    = 6
) (
    input  logic [CREDIT_W-1:0] credit,
    input  logic [INV_W-1:0]    inv_nickel,
    input  logic [INV_W-1:0]    inv_dime,
    input  logic [INV_W-1:0]    inv_quarter,
    input  logic [INV_W-1:0]    inv_half,
    output logic [2:0]          coin_type,
    output logic                found
);

    always_comb begin
        coin_type = COIN_NONE;
        found     = 1'b0;
        if (credit >= CREDIT_W'(U_HALF) && inv_half != '0) begin
            coin_type = COIN_HALF;
            found     = 1'b1;
        end else if (credit >= CREDIT_W'(U_QUARTER) && inv_quarter != '0) begin
            coin_type = COIN_QUARTER;
            found     = 1'b1;
        end else if (credit >= CREDIT_W'(U_DIME) && inv_dime != '0) begin
            coin_type = COIN_DIME;
            found     = 1'b1;
        end else if (credit >= CREDIT_W'(U_NICKEL) && inv_nickel != '0) begin
            coin_type = COIN_NICKEL;
            found     = 1'b1;
        end
    end

endmodule

// File: rtl/vending_ctrl_param.sv
// Vending controller: N priced slots, nickel-unit credit, coin inventory, one-coin-per-cycle change.
// Registered outputs update one cycle after the strobe; change waits on chg_ready with chg_type held.
module vending_ctrl_param
    import vm_pkg::*;
#(
    parameter int N_PROD     = 6,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200,
    parameter int INV_W      = 6,
    parameter int INV_INIT   = 10,
    localparam int SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coin_valid,
    input  logic [2:0]                 coin_type,
    input  logic                       sel_valid,
    input  logic [SEL_W-1:0]           sel_idx,
    input  logic                       refund,
    input  logic [N_PROD*CREDIT_W-1:0] prices,
    input  logic [N_PROD-1:0]          sold_out,
    input  logic                       vend_ack,
    input  logic                       chg_ready,
    input  logic                       svc_load,
    input  logic [2:0]                 svc_type,
    input  logic [INV_W-1:0]           svc_count,
    output logic [CREDIT_W-1:0]        credit,
    output logic [1:0]                 state,
    output logic                       vend_valid,
    output logic [SEL_W-1:0]           vend_idx,
    output logic                       chg_valid,
    output logic [2:0]                 chg_type,
    output logic                       coin_reject,
    output logic                       err_sold_out,
    output logic                       err_funds,
    output logic                       err_short,
    output logic                       exact_change,
    output logic [INV_W-1:0]           inv_nickel,
    output logic [INV_W-1:0]           inv_dime,
    output logic [INV_W-1:0]           inv_quarter,
    output logic [INV_W-1:0]           inv_half
);

    localparam int CW1 = CREDIT_W + 1;

    if (!max_credit_ok(CREDIT_W, MAX_CREDIT)) begin : g_cfg_bad
        $error("MAX_CREDIT does not leave headroom for a dollar in CREDIT_W bits");
    end

    state_t              st_q, st_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [SEL_W-1:0]    vend_idx_d;
    logic [INV_W-1:0]    inv_q [4];
    logic [INV_W-1:0]    inv_d [4];
    logic                rej_d, eso_d, efu_d, esh_d, exact_d;

    logic [CREDIT_W-1:0] coin_val, sel_price, pick_val;
    logic [CW1-1:0]      coin_sum;
    logic                coin_ok, sel_so;
    logic [2:0]          pick_type;
    logic                pick_found;

    vm_change_pick #(
        .CREDIT_W (CREDIT_W),
        .INV_W    (INV_W)
    ) u_pick (
        .credit      (credit),
        .inv_nickel  (inv_q[0]),
        .inv_dime    (inv_q[1]),
        .inv_quarter (inv_q[2]),
        .inv_half    (inv_q[3]),
        .coin_type   (pick_type),
        .found       (pick_found)
    );

    assign pick_val  = CREDIT_W'(coin_units(pick_type));
    assign chg_valid = (st_q == ST_CHANGE) && pick_found;
    assign chg_type  = chg_valid ? pick_type : COIN_NONE;

    // Out-of-range indices read as sold out so they never reach the price compare.
    always_comb begin
        sel_price = '0;
        sel_so    = 1'b1;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_idx == SEL_W'(i)) begin
                sel_price = prices[i*CREDIT_W +: CREDIT_W];
                sel_so    = sold_out[i];
            end
        end
    end

    always_comb begin
        st_d       = st_q;
        credit_d   = credit;
        vend_idx_d = vend_idx;
        inv_d      = inv_q;
        rej_d      = 1'b0;
        eso_d      = 1'b0;
        efu_d      = 1'b0;
        esh_d      = 1'b0;

        coin_val = CREDIT_W'(coin_units(coin_type));
        coin_sum = {1'b0, credit} + {1'b0, coin_val};
        coin_ok  = coin_valid && (st_q == ST_IDLE || st_q == ST_CREDIT)
                   && !refund && !sel_valid && (coin_val != '0)
                   && (coin_sum <= CW1'(MAX_CREDIT));

        if (coin_valid && !coin_ok)
            rej_d = 1'b1;
        if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            if (st_q == ST_IDLE)
                st_d = ST_CREDIT;
            if (coin_in_inv(coin_type) && inv_q[coin_slot(coin_type)] != '1)
                inv_d[coin_slot(coin_type)] = inv_q[coin_slot(coin_type)] + INV_W'(1);
        end

        case (st_q)
            ST_IDLE: begin
                if (svc_load && coin_in_inv(svc_type))
                    inv_d[coin_slot(svc_type)] = svc_count;
            end
            ST_CREDIT: begin
                if (refund) begin
                    st_d = ST_CHANGE;
                end else if (sel_valid) begin
                    if (sel_so) begin
                        eso_d = 1'b1;
                    end else if (credit < sel_price) begin
                        efu_d = 1'b1;
                    end else begin
                        credit_d   = credit - sel_price;
                        vend_idx_d = sel_idx;
                        st_d       = ST_VEND;
                    end
                end
            end
            ST_VEND: begin
                if (vend_ack)
                    st_d = (credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (credit == '0) begin
                    st_d = ST_IDLE;
                end else if (!pick_found) begin
                    esh_d = 1'b1;
                    st_d  = ST_CREDIT;
                end else if (chg_ready) begin
                    credit_d = credit - pick_val;
                    inv_d[coin_slot(pick_type)] = inv_q[coin_slot(pick_type)] - INV_W'(1);
                    if (credit_d == '0)
                        st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        exact_d = (inv_d[0] == '0) || (inv_d[1] == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q         <= ST_IDLE;
            credit       <= '0;
            vend_valid   <= 1'b0;
            vend_idx     <= '0;
            coin_reject  <= 1'b0;
            err_sold_out <= 1'b0;
            err_funds    <= 1'b0;
            err_short    <= 1'b0;
            exact_change <= (INV_INIT == 0);
            for (int i = 0; i < 4; i++)
                inv_q[i] <= INV_W'(INV_INIT);
        end else begin
            st_q         <= st_d;
            credit       <= credit_d;
            vend_valid   <= (st_d == ST_VEND);
            vend_idx     <= vend_idx_d;
            coin_reject  <= rej_d;
            err_sold_out <= eso_d;
            err_funds    <= efu_d;
            err_short    <= esh_d;
            exact_change <= exact_d;
            for (int i = 0; i < 4; i++)
                inv_q[i] <= inv_d[i];
        end
    end

    assign state       = st_q;
    assign inv_nickel  = inv_q[0];
    assign inv_dime    = inv_q[1];
    assign inv_quarter = inv_q[2];
    assign inv_half    = inv_q[3];

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Scoreboarded bench: stimulus pushes expected change coins, vends and pulses; a monitor pops and compares.
module tb_vending_ctrl_param;

    localparam int NP = 6;
    localparam int CW = 8;
    localparam int IW = 6;

    localparam int NICKEL = 1, DIME = 2, QUARTER = 3, HALF = 4, DOLLAR = 5;
    localparam int P_REJ = 1, P_SOLD = 2, P_FUNDS = 3, P_SHORT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            coin_valid = 1'b0;
    logic [2:0]      coin_type = 3'd0;
    logic            sel_valid = 1'b0;
    logic [2:0]      sel_idx = 3'd0;
    logic            refund = 1'b0;
    logic [NP*CW-1:0] prices = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    logic [NP-1:0]   sold_out = 6'b010000;
    logic            vend_ack = 1'b0;
    logic            chg_ready = 1'b1;
    logic            svc_load = 1'b0;
    logic [2:0]      svc_type = 3'd0;
    logic [IW-1:0]   svc_count = '0;
    logic [CW-1:0]   credit;
    logic [1:0]      state;
    logic            vend_valid;
    logic [2:0]      vend_idx;
    logic            chg_valid;
    logic [2:0]      chg_type;
    logic            coin_reject, err_sold_out, err_funds, err_short, exact_change;
    logic [IW-1:0]   inv_nickel, inv_dime, inv_quarter, inv_half;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_chg[$];
    int exp_vend[$];
    int exp_pulse[$];

    vending_ctrl_param #(
        .N_PROD(NP), .CREDIT_W(CW), .MAX_CREDIT(200), .INV_W(IW), .INV_INIT(10)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .refund(refund), .prices(prices),
        .sold_out(sold_out), .vend_ack(vend_ack), .chg_ready(chg_ready),
        .svc_load(svc_load), .svc_type(svc_type), .svc_count(svc_count),
        .credit(credit), .state(state), .vend_valid(vend_valid), .vend_idx(vend_idx),
        .chg_valid(chg_valid), .chg_type(chg_type), .coin_reject(coin_reject),
        .err_sold_out(err_sold_out), .err_funds(err_funds), .err_short(err_short),
        .exact_change(exact_change), .inv_nickel(inv_nickel), .inv_dime(inv_dime),
        .inv_quarter(inv_quarter), .inv_half(inv_half)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d with nothing expected (t=%0t)", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int t);
        coin_valid = 1'b1;
        coin_type  = 3'(t);
        tick();
        coin_valid = 1'b0;
        coin_type  = 3'd0;
    endtask

    task automatic coins(input int t, input int n);
        for (int i = 0; i < n; i++) coin(t);
    endtask

    task automatic select(input int idx);
        sel_valid = 1'b1;
        sel_idx   = 3'(idx);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_refund();
        refund = 1'b1;
        tick();
        refund = 1'b0;
    endtask

    task automatic service(input int t, input int cnt);
        svc_load  = 1'b1;
        svc_type  = 3'(t);
        svc_count = IW'(cnt);
        tick();
        svc_load = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n = 0;
        while (int'(state) != target && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(state), target);
    endtask

    // Monitor: every handshake, vend start and pulse is matched against the queues.
    initial begin
        logic vend_prev;
        logic [3:0] pulses;
        vend_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (chg_valid && chg_ready) begin
                    if (exp_chg.size() == 0) unexpected("chg_coin", int'(chg_type));
                    else check("chg_coin", int'(chg_type), exp_chg.pop_front());
                end
                if (vend_valid && !vend_prev) begin
                    if (exp_vend.size() == 0) unexpected("vend_idx", int'(vend_idx));
                    else check("vend_idx", int'(vend_idx), exp_vend.pop_front());
                end
                pulses = {err_short, err_funds, err_sold_out, coin_reject};
                for (int k = 0; k < 4; k++) begin
                    if (pulses[k]) begin
                        if (exp_pulse.size() == 0) unexpected("pulse", k + 1);
                        else check("pulse", k + 1, exp_pulse.pop_front());
                    end
                end
            end
            vend_prev = vend_valid;
        end
    end

    initial begin
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_state", int'(state), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_vend_valid", int'(vend_valid), 0);
        check("rst_chg_valid", int'(chg_valid), 0);
        check("rst_chg_type", int'(chg_type), 0);
        check("rst_inv_half", int'(inv_half), 10);
        check("rst_exact", int'(exact_change), 0);

        // 40 units, buy slot 2 at 30, change one half-dollar
        coins(QUARTER, 8);
        check("t1_credit", int'(credit), 40);
        check("t1_state", int'(state), 1);
        exp_vend.push_back(2);
        select(2);
        check("t1_vend_state", int'(state), 2);
        check("t1_vend_credit", int'(credit), 10);
        exp_pulse.push_back(P_REJ);
        coin(DIME);
        check("t1_vend_coin_credit", int'(credit), 10);
        check("t1_vend_hold", int'(vend_valid), 1);
        exp_chg.push_back(HALF);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        check("t1_change_state", int'(state), 3);
        wait_state(0, 5, "t1_idle");
        check("t1_credit0", int'(credit), 0);
        check("t1_inv_half", int'(inv_half), 9);
        check("t1_inv_quarter", int'(inv_quarter), 18);

        // Ceiling, reject, then a long refund that drains half/quarter/dime
        coins(DOLLAR, 10);
        check("t2_credit", int'(credit), 200);
        exp_pulse.push_back(P_REJ);
        coin(NICKEL);
        check("t2_reject_credit", int'(credit), 200);
        check("t2_inv_nickel", int'(inv_nickel), 10);
        exp_pulse.push_back(P_REJ);
        coin(7);
        check("t2_badtype_credit", int'(credit), 200);
        for (int i = 0; i < 9; i++) exp_chg.push_back(HALF);
        for (int i = 0; i < 18; i++) exp_chg.push_back(QUARTER);
        for (int i = 0; i < 10; i++) exp_chg.push_back(DIME);
        do_refund();
        wait_state(0, 60, "t2_idle");
        check("t2_inv_half", int'(inv_half), 0);
        check("t2_inv_quarter", int'(inv_quarter), 0);
        check("t2_inv_dime", int'(inv_dime), 0);
        check("t2_exact", int'(exact_change), 1);
        service(HALF, 10);
        service(QUARTER, 10);
        service(DIME, 10);
        check("t2_svc_half", int'(inv_half), 10);
        check("t2_svc_dime", int'(inv_dime), 10);
        check("t2_svc_exact", int'(exact_change), 0);

        // Sold-out and out-of-range slots; service ignored outside IDLE
        coins(QUARTER, 8);
        exp_pulse.push_back(P_SOLD);
        select(4);
        check("t3_credit", int'(credit), 40);
        check("t3_state", int'(state), 1);
        exp_pulse.push_back(P_SOLD);
        select(7);
        check("t3_range_state", int'(state), 1);
        service(NICKEL, 0);
        check("t3_svc_ignored", int'(inv_nickel), 10);
        for (int i = 0; i < 4; i++) exp_chg.push_back(HALF);
        do_refund();
        wait_state(0, 10, "t3_idle");

        // Insufficient funds, then refund with the hopper stalled
        coins(QUARTER, 5);
        exp_pulse.push_back(P_FUNDS);
        select(2);
        check("t4_credit", int'(credit), 25);
        check("t4_state", int'(state), 1);
        chg_ready = 1'b0;
        exp_chg.push_back(HALF);
        exp_chg.push_back(HALF);
        exp_chg.push_back(QUARTER);
        do_refund();
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", int'(chg_valid), 1);
            check("t4_stall_type", int'(chg_type), HALF);
            tick();
        end
        check("t4_stall_credit", int'(credit), 25);
        chg_ready = 1'b1;
        wait_state(0, 10, "t4_idle");
        check("t4_inv_half", int'(inv_half), 4);
        check("t4_inv_quarter", int'(inv_quarter), 22);

        // No nickels: 3 units of change stops short at 1
        service(NICKEL, 0);
        check("t5_exact", int'(exact_change), 1);
        coin(QUARTER);
        coins(DIME, 4);
        check("t5_credit", int'(credit), 13);
        exp_vend.push_back(0);
        select(0);
        check("t5_vend_credit", int'(credit), 3);
        exp_chg.push_back(DIME);
        exp_pulse.push_back(P_SHORT);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        wait_state(1, 10, "t5_short_state");
        check("t5_short_credit", int'(credit), 1);
        check("t5_inv_dime", int'(inv_dime), 13);

        // Asynchronous reset in the middle of a stalled change
        coin(HALF);
        check("t6_credit", int'(credit), 11);
        chg_ready = 1'b0;
        do_refund();
        check("t6_change_type", int'(chg_type), HALF);
        rst = 1'b0;
        #2;
        check("t6_rst_state", int'(state), 0);
        check("t6_rst_credit", int'(credit), 0);
        check("t6_rst_chg_valid", int'(chg_valid), 0);
        check("t6_rst_inv_half", int'(inv_half), 10);
        @(negedge clk);
        rst = 1'b1;
        chg_ready = 1'b1;
        tick();
        tick();

        check("chg_queue_left", exp_chg.size(), 0);
        check("vend_queue_left", exp_vend.size(), 0);
        check("pulse_queue_left", exp_pulse.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
